// File: rtl/fp32_addsub_arbiter_if.sv
// Requester-side bus of the shared FP32 add/sub arbiter: packed per-requester
// operation requests with their one-hot grant, and the routed result strobe.
interface fp32_addsub_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_op;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_result;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/fp32_addsub_arbiter.sv
// Round-robin sharing of one pipelined FP32 add/sub unit among NREQ requesters,
// with a requester-ID tag pipeline that routes each result back to its issuer.
module fp32_addsub_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fp32_addsub_arbiter_if.slave bus,
  output logic                 fpu_valid,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic                 fpu_op,
  input  logic [31:0]          fpu_result,
  input  logic                 drain,
  output logic                 busy,
  output logic                 drain_done
);
  localparam int CW = $clog2(LATENCY + 3);

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    win_id;
  logic [IDW-1:0]    issue_id;
  logic [2*NREQ-1:0] rot;
  logic              found;
  logic              accept;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic              sel_op;
  logic [LATENCY-1:0] tag_v;
  logic [IDW-1:0]    tag_id [LATENCY];
  logic [CW-1:0]     inflight;

  // Rotating the doubled request vector by the pointer turns the wrapped
  // search into a plain lowest-set-bit scan.
  always_comb begin
    rot    = {bus.req_valid, bus.req_valid} >> ptr;
    found  = 1'b0;
    win_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found  = 1'b1;
        win_id = IDW'((32'(ptr) + k) % NREQ);
      end
    end
    accept        = found && !drain && !rst;
    bus.req_ready = accept ? (NREQ'(1) << win_id) : '0;
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_id == IDW'(k)) begin
        sel_a  = bus.req_a[32*k +: 32];
        sel_b  = bus.req_b[32*k +: 32];
        sel_op = bus.req_op[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      fpu_valid <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= 1'b0;
      issue_id  <= '0;
    end else begin
      fpu_valid <= accept;
      if (accept) begin
        ptr      <= IDW'((32'(win_id) + 1) % NREQ);
        fpu_a    <= sel_a;
        fpu_b    <= sel_b;
        fpu_op   <= sel_op;
        issue_id <= win_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= fpu_valid;
      for (int unsigned k = 1; k < LATENCY; k++) tag_v[k] <= tag_v[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= issue_id;
    for (int unsigned k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
    end else begin
      bus.rsp_valid <= '0;
      if (tag_v[LATENCY-1]) begin
        bus.rsp_valid  <= NREQ'(1) << tag_id[LATENCY-1];
        bus.rsp_result <= fpu_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, |bus.rsp_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (32'(inflight) <= LATENCY + 2);
  end

  assign busy       = (inflight != '0);
  assign drain_done = drain && !busy;
endmodule

// File: tb/tb_fp32_addsub_arbiter.sv
// Bench for fp32_addsub_arbiter: three instances (LATENCY 3, 1, 16) share one
// stimulus stream; a grant model and per-instance result queues check them.
module tb_fp32_addsub_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [31:0]    cyc;
    logic [IDW-1:0] id;
    logic [31:0]    res;
  } exp_t;

  function automatic int lat_of(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 1 : 16);
  endfunction

  // Exact for the small-integer operands used here.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == '0) d = {f[31], 63'b0};
    else               d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'b0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    return op ? r2f(f2r(a) - f2r(b)) : r2f(f2r(a) + f2r(b));
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    s_valid;
  logic [32*NREQ-1:0] s_a;
  logic [32*NREQ-1:0] s_b;
  logic [NREQ-1:0]    s_op;
  logic               s_drain;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int m_ptr = 0;
  exp_t exp_q [NDUT][$];
  int peak [NDUT];

  logic [NREQ-1:0] ready_w [NDUT];
  logic            busy_w  [NDUT];
  logic            dd_w    [NDUT];
  logic            fv_w    [NDUT];
  logic [31:0]     fa_w    [NDUT];
  logic [IDW-1:0]  ptr_w   [NDUT];
  logic [31:0]     infl_w  [NDUT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int LAT = lat_of(g);
    fp32_addsub_arbiter_if #(.NREQ(NREQ)) bus ();
    logic        fpu_valid, fpu_op, busy, drain_done;
    logic [31:0] fpu_a, fpu_b, fpu_result;
    logic [31:0] pipe [LAT];

    assign bus.req_valid = s_valid;
    assign bus.req_a     = s_a;
    assign bus.req_b     = s_b;
    assign bus.req_op    = s_op;

    fp32_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW), .LATENCY(LAT)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .fpu_valid  (fpu_valid),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_op     (fpu_op),
      .fpu_result (fpu_result),
      .drain      (s_drain),
      .busy       (busy),
      .drain_done (drain_done)
    );

    // Shared-unit model: result of the operands issued LAT cycles earlier.
    always @(posedge clk) begin
      pipe[0] <= fp_model(fpu_a, fpu_b, fpu_op);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign fpu_result = pipe[LAT-1];

    assign ready_w[g] = bus.req_ready;
    assign busy_w[g]  = busy;
    assign dd_w[g]    = drain_done;
    assign fv_w[g]    = fpu_valid;
    assign fa_w[g]    = fpu_a;
    assign ptr_w[g]   = u_dut.ptr;
    assign infl_w[g]  = 32'(u_dut.inflight);

    always @(negedge clk) begin : mon
      exp_t e;
      if (int'(infl_w[g]) > peak[g]) peak[g] = int'(infl_w[g]);
      if (bus.rsp_valid != '0) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("rsp_unexpected_L%0d", LAT), 64'(bus.rsp_valid), 64'(0));
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("rsp_valid_L%0d", LAT), 64'(bus.rsp_valid), 64'(NREQ'(1) << e.id));
          check($sformatf("rsp_result_L%0d", LAT), 64'(bus.rsp_result), 64'(e.res));
          check($sformatf("rsp_latency_L%0d", LAT), 64'(cyc - e.cyc), 64'(2 + LAT));
        end
      end
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      s_a[32*i +: 32] = r2f($itor($urandom_range(1, 200)));
      s_b[32*i +: 32] = r2f($itor($urandom_range(1, 200)));
      s_op[i]         = 1'($urandom_range(0, 1));
    end
  endtask

  // One cycle: apply requests, check the grant against the model, push expectations.
  task automatic drive(input logic [NREQ-1:0] v, input logic drn);
    exp_t e;
    logic [NREQ-1:0] eg;
    int w;
    s_valid = v;
    s_drain = drn;
    @(negedge clk);
    w = -1;
    if (!rst && !drn)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    eg = (w >= 0) ? (NREQ'(1) << w) : '0;
    for (int g = 0; g < NDUT; g++)
      check($sformatf("req_ready_L%0d", lat_of(g)), 64'(ready_w[g]), 64'(eg));
    if (w >= 0) begin
      e.cyc = cyc;
      e.id  = IDW'(w);
      e.res = fp_model(s_a[32*w +: 32], s_b[32*w +: 32], s_op[w]);
      for (int g = 0; g < NDUT; g++) exp_q[g].push_back(e);
      m_ptr = (w + 1) % NREQ;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0);
  endtask

  function automatic logic all_dd();
    logic r;
    r = 1'b1;
    for (int g = 0; g < NDUT; g++) r &= dd_w[g];
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = '1; s_drain = 1'b0; s_a = '0; s_b = '0; s_op = '0;
    for (int g = 0; g < NDUT; g++) peak[g] = 0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("reset_ready", 64'(ready_w[g]), 64'(0));
      check("reset_fpu_valid", 64'(fv_w[g]), 64'(0));
      check("reset_busy", 64'(busy_w[g]), 64'(0));
      check("reset_ptr", 64'(ptr_w[g]), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0; s_valid = '0;

    // Single request from requester 2: 1.0 + 2.0
    rand_ops();
    s_a[64 +: 32] = 32'h3F80_0000;
    s_b[64 +: 32] = 32'h4000_0000;
    s_op[2]       = 1'b0;
    drive(4'b0100, 1'b0);
    s_valid = '0;
    @(negedge clk);
    check("single_fpu_valid", 64'(fv_w[0]), 64'(1));
    check("single_fpu_a", 64'(fa_w[0]), 64'h3F80_0000);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      check("single_busy", 64'(busy_w[0]), 64'(1));
      check("single_inflight", 64'(infl_w[0]), 64'(1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("single_busy_drop", 64'(busy_w[0]), 64'(0));
    @(posedge clk); #1;
    idle(20);

    // Fairness from pointer 0
    drive(4'b1000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      drive('1, 1'b0);
    end
    idle(22);

    // Pointer wrap
    drive(4'b0100, 1'b0);
    check("wrap_ptr3", 64'(ptr_w[0]), 64'(3));
    drive(4'b1010, 1'b0);
    check("wrap_ptr0", 64'(ptr_w[0]), 64'(0));
    drive(4'b1010, 1'b0);
    check("wrap_ptr2", 64'(ptr_w[1]), 64'(2));
    idle(22);

    // Drain with three operations in flight
    drive(4'b0010, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b1000, 1'b0);
    drive(4'b0001, 1'b1);
    check("drain_done_early", 64'(dd_w[0]), 64'(0));
    for (int t = 0; t < 40 && !all_dd(); t++) drive(4'b0001, 1'b1);
    check("drain_done_seen", 64'(all_dd()), 64'(1));
    for (int g = 0; g < NDUT; g++)
      check("drain_all_delivered", 64'(exp_q[g].size()), 64'(0));
    drive(4'b0001, 1'b0);

    // Reset with operations in flight
    rand_ops();
    drive('1, 1'b0);
    drive('1, 1'b0);
    rst = 1'b1;
    s_valid = '1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check("midrst_ready", 64'(ready_w[g]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = '0;
    m_ptr = 0;
    for (int g = 0; g < NDUT; g++) begin
      exp_q[g].delete();
      check("midrst_ptr", 64'(ptr_w[g]), 64'(0));
      check("midrst_busy", 64'(busy_w[g]), 64'(0));
    end
    idle(22);

    // Full-throughput stream from requester 1
    for (int g = 0; g < NDUT; g++) peak[g] = 0;
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      s_op[1] = 1'(i % 2);
      drive(4'b0010, 1'b0);
    end
    idle(24);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("stream_peak_L%0d", lat_of(g)), 64'(peak[g]), 64'(lat_of(g) + 2));
      check("final_queue_empty", 64'(exp_q[g].size()), 64'(0));
      check("final_busy", 64'(busy_w[g]), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp32_addsub_arbiter.md
Name: fp32_addsub_arbiter

Overview:
- Round-robin arbiter that shares one pipelined FP32 add/sub unit among NREQ requesters.
- Accepts at most one operation per cycle and drives the shared unit's operand and opmode inputs.
- Tracks the requester ID of each in-flight operation in a LATENCY-deep tag pipeline and routes each returning result to the requester that issued it.
- Provides a drain mode for quiescing the shared unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.
- LATENCY, 3, fixed cycles from fpu_valid to the matching fpu_result (1..16).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester operation request.
- req_a  input  32*NREQ  operand A, packed; requester i uses bits [32i+31:32i].
- req_b  input  32*NREQ  operand B, packed the same way.
- req_op  input  NREQ  per-requester opmode (0 = add, 1 = sub).
- req_ready  output  NREQ  one-hot grant; the request is accepted when req_valid[i] and req_ready[i] are both high.
- fpu_valid  output  1  issue strobe to the shared unit.
- fpu_a  output  32  operand A to the shared unit.
- fpu_b  output  32  operand B to the shared unit.
- fpu_op  output  1  opmode to the shared unit.
- fpu_result  input  32  result from the shared unit, valid exactly LATENCY cycles after fpu_valid.
- rsp_valid  output  NREQ  one-hot result strobe, asserted for one cycle.
- rsp_result  output  32  result data, valid while any rsp_valid bit is high.
- drain  input  1  level; while high, no new grants are issued.
- busy  output  1  high while any operation is in flight.
- drain_done  output  1  equals drain AND NOT busy.

Behaviour:
- Reset:
  - req_ready=0, fpu_valid=0, fpu_a/fpu_b=0, fpu_op=0.
  - rsp_valid=0, rsp_result=0, busy=0.
  - Round-robin pointer resets to requester 0.
  - Tag pipeline valid bits are cleared; in-flight operations are discarded and their results are never delivered.
- Arbitration (combinational from current inputs and pointer):
  - The first requester with req_valid set wins, searching from the pointer upward and wrapping mod NREQ.
  - req_ready is one-hot on the winner. It is 0 when no request is pending, when drain=1, or when rst=1.
  - req_ready does not depend on whether the shared unit is busy; the unit accepts one operation every cycle.
- Pointer update: on an accepted grant to requester i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- Issue register (1 cycle):
  - On a grant, the next cycle has fpu_valid=1 and fpu_a/fpu_b/fpu_op taken from the winner.
  - With no grant, fpu_valid=0 and the operand registers hold their previous values.
- Tag pipeline:
  - A LATENCY-stage shift register of {valid, id} is loaded from {fpu_valid, issued id}.
  - When the last stage is valid, in the same cycle fpu_result is captured into rsp_result and rsp_valid[id] is set on the next edge.
  - Total latency is 2+LATENCY cycles from the accept edge to rsp_valid: 1 cycle issue, LATENCY cycles unit, 1 cycle response register.
  - rsp_valid is cleared in any cycle with no returning result; rsp_result holds its value.
- In-flight counter:
  - Width is clog2(LATENCY+3).
  - Increments on an accepted grant and decrements on each rsp_valid pulse; an increment and decrement in the same cycle leave it unchanged.
  - busy = (counter != 0).
  - The counter can never exceed LATENCY+2; a count past that is an assertion failure.
- Drain:
  - Asserting drain blocks grants in the same cycle.
  - Operations already accepted complete normally.
  - drain_done rises the cycle after the last rsp_valid.
  - Deasserting drain resumes grants immediately, keeping the current pointer.
- Simultaneous events:
  - A grant and a result delivery in the same cycle are independent.
  - A requester may receive a result and be granted again in the same cycle.
- Back-to-back: a single requester holding req_valid alone is granted every cycle, giving full throughput.
- Responses cannot be stalled; requesters must sink rsp_valid every cycle.

Test Plan:
- Reset then a single request: requester 2 sends a=0x3F800000, b=0x40000000, op=0 → req_ready=0b0100 in cycle 0; fpu_valid in cycle 1; rsp_valid=0b0100 with rsp_result equal to the unit model's 0x40400000 in cycle 2+LATENCY. The counter reads 1 until then and busy drops the cycle after.
- Fairness: all four requesters hold req_valid for 8 cycles with the pointer at 0 → grants are 0,1,2,3,0,1,2,3 and each requester gets exactly 2 results, in issue order.
- Pointer wrap: pointer=3, requesters 1 and 3 valid → grant 3, then grant 1; the pointer becomes 0 and then 2.
- Drain mid-stream: drain rises while 3 ops are in flight and requester 0 is valid → no req_ready; 3 rsp_valid pulses follow, then drain_done=1. Dropping drain grants requester 0 the next cycle.
- Reset mid-operation: rst is asserted for 1 cycle with 2 ops in flight → no rsp_valid afterwards, busy=0, and the pointer is at 0 on the next cycle.
- Full throughput with LATENCY=1 and LATENCY=16: a single requester streams 20 ops with op alternating → 20 results in order, no gaps after the first, and the counter peaks at LATENCY+2.
